fifo_rd_unpack: RTL and testbench



---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_rd_unpack_shreg.sv | 62 ++++++
 rtl/fifo_rd_unpack.sv | 130 +++++++++++++
 tb/tb_fifo_rd_unpack.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants, FSM encoding and sizing helpers for the FIFO read-side unpacker.
package fifo_pkg;

  localparam int FIFO_W = 560;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  function automatic int ns_f(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  function automatic int idx_w_f(input int ns);
    return (ns > 1) ? $clog2(ns) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_unpack_shreg.sv
// Word register that shifts right by OUT_W per accepted slice, so the current slice is always the low bits.
// last is a flop that is high only while the final slice is presented; load takes priority over shift.
module unpack_shreg
  import fifo_pkg::*;
#(
  parameter int IN_W  = FIFO_W,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IN_W-1:0]  load_dat,
  input  logic             shift,
  output logic [OUT_W-1:0] slice,
  output logic             last
);

  localparam int NS = ns_f(IN_W, OUT_W);
  localparam int IW = idx_w_f(NS);
  localparam logic [IW-1:0] IDX_LAST = IW'(NS - 1);

  logic [IN_W-1:0] word_q, word_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            last_q, last_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    last_d = last_q;
    if (load) begin
      word_d = load_dat;
      idx_d  = '0;
      last_d = (NS == 1);
    end else if (shift) begin
      // The final shift empties the register, so m_data drops back to zero between words.
      word_d = word_q >> OUT_W;
      if (idx_q == IDX_LAST) begin
        idx_d  = '0;
        last_d = 1'b0;
      end else begin
        idx_d  = idx_q + IW'(1);
        last_d = ((idx_q + IW'(1)) == IDX_LAST);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      last_q <= last_d;
    end
  end

  assign slice = word_q[OUT_W-1:0];
  assign last  = last_q;

endmodule

// File: rtl/fifo_rd_unpack.sv
// Pops one wide word from the async FIFO read port and streams it out as IN_W/OUT_W slices, LSB first.
// First slice RD_LAT+1 cycles after the pop; m_valid/m_data hold while m_ready is low.
module fifo_rd_unpack
  import fifo_pkg::*;
#(
  parameter int IN_W   = FIFO_W,
  parameter int OUT_W  = 16,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic             r_clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [IN_W-1:0]  fifo_rd_data,
  output logic [OUT_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [CNT_W-1:0] word_cnt,
  output logic             busy
);

  localparam int LW = 2;
  localparam logic [LW-1:0] LAT_DONE = LW'(RD_LAT);

  generate
    if (IN_W % OUT_W != 0) begin : g_bad_width
      $error("fifo_rd_unpack: IN_W must be a multiple of OUT_W");
    end
    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
      $error("fifo_rd_unpack: RD_LAT must be in 1..3");
    end
  endgenerate

  state_e           state_q, state_d;
  logic             rd_en_q, rd_en_d;
  logic             valid_q, valid_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             busy_q, busy_d;
  logic             load, shift, last;
  logic [OUT_W-1:0] slice;

  always_comb begin
    state_d = state_q;
    rd_en_d = 1'b0;
    valid_d = valid_q;
    lat_d   = lat_q;
    wcnt_d  = wcnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          rd_en_d = 1'b1;
          lat_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_q == LAT_DONE) begin
          load    = 1'b1;
          valid_d = 1'b1;
          state_d = ST_OUT;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          shift = 1'b1;
          // Final slice accepted: chain straight into the next pop to keep the gap at RD_LAT+1.
          if (last) begin
            wcnt_d  = wcnt_q + CNT_W'(1);
            valid_d = 1'b0;
            if (!fifo_empty) begin
              rd_en_d = 1'b1;
              lat_d   = '0;
              state_d = ST_WAIT;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      lat_q   <= '0;
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      valid_q <= valid_d;
      lat_q   <= lat_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= busy_d;
    end
  end

  unpack_shreg #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_shreg (
    .clk      (r_clk),
    .rst      (rst),
    .load     (load),
    .load_dat (fifo_rd_data),
    .shift    (shift),
    .slice    (slice),
    .last     (last)
  );

  assign fifo_rd_en = rd_en_q;
  assign m_valid    = valid_q;
  assign m_data     = slice;
  assign m_last     = last;
  assign word_cnt   = wcnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fifo_rd_unpack.sv
// Bench for fifo_rd_unpack: queue-based FIFO model, transfer monitor and per-scenario checks.
module tb_fifo_rd_unpack;

  localparam int IN_W   = 560;
  localparam int OUT_W  = 16;
  localparam int RD_LAT = 1;
  localparam int CNT_W  = 16;
  localparam int NS     = IN_W / OUT_W;

  logic             r_clk = 1'b0;
  logic             rst = 1'b1;
  logic             fifo_empty = 1'b1;
  logic             fifo_rd_en;
  logic [IN_W-1:0]  fifo_rd_data;
  logic [OUT_W-1:0] m_data;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic             m_last;
  logic [CNT_W-1:0] word_cnt;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;
  int exp_wc = 0;
  int t_pop = 0;
  bit force_empty = 1'b0;

  logic [IN_W-1:0]  fifo_q[$];
  logic [IN_W-1:0]  rd_pipe[RD_LAT] = '{default: '0};
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] rx_q[$];
  bit               rx_last[$];
  int               rx_cyc[$];
  logic [IN_W-1:0]  words[16];

  bit               stall_q = 1'b0;
  logic [OUT_W-1:0] stall_dat = '0;
  int               slice_pos = 0;

  fifo_rd_unpack #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .RD_LAT (RD_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .r_clk        (r_clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .word_cnt     (word_cnt),
    .busy         (busy)
  );

  always #5 r_clk = ~r_clk;

  always @(posedge r_clk) cyc <= cyc + 1;

  // FIFO read port model: a pop seen on an edge presents the word RD_LAT cycles later.
  always @(posedge r_clk) begin
    if (fifo_rd_en && !rst) begin
      if (fifo_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fifo_underflow: pop issued with model FIFO empty at cycle %0d", cyc);
      end else begin
        rd_pipe[0] <= fifo_q.pop_front();
        pops++;
      end
    end
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign fifo_rd_data = rd_pipe[RD_LAT-1];

  // Stream monitor: records transfers and checks hold/last/pop rules every cycle.
  always @(negedge r_clk) begin
    if (!rst) begin
      if (fifo_rd_en) begin
        checks++;
        if (fifo_empty !== 1'b0) begin
          errors++;
          $display("FAIL pop_when_empty: fifo_rd_en=1 with fifo_empty=%b at cycle %0d", fifo_empty, cyc);
        end
      end
      if (stall_q) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== stall_dat) begin
          errors++;
          $display("FAIL stall_hold: m_valid=%b m_data=%h, required 1 and %h at cycle %0d",
                   m_valid, m_data, stall_dat, cyc);
        end
      end
      if (m_valid || m_last) begin
        checks++;
        if (m_last !== (m_valid && slice_pos == NS-1)) begin
          errors++;
          $display("FAIL m_last: got %b, required %b at slice position %0d cycle %0d",
                   m_last, (m_valid && slice_pos == NS-1), slice_pos, cyc);
        end
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        rx_q.push_back(m_data);
        rx_last.push_back(m_last);
        rx_cyc.push_back(cyc);
        slice_pos = (slice_pos == NS-1) ? 0 : slice_pos + 1;
      end
      stall_q   = (m_valid === 1'b1) && (m_ready === 1'b0);
      stall_dat = m_data;
    end else begin
      stall_q   = 1'b0;
      slice_pos = 0;
    end
    fifo_empty = force_empty || (fifo_q.size() == 0);
  end

  function automatic logic [IN_W-1:0] rand_word();
    logic [IN_W-1:0] w;
    for (int i = 0; i < IN_W/16; i++) w[i*16 +: 16] = 16'($urandom);
    return w;
  endfunction

  task automatic push_word(input logic [IN_W-1:0] w);
    fifo_q.push_back(w);
    for (int k = 0; k < NS; k++) exp_q.push_back(w[k*OUT_W +: OUT_W]);
    exp_wc++;
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_last.delete();
    rx_cyc.delete();
    exp_q.delete();
  endtask

  task automatic wait_rx(input int n, input bit rnd, output bit ok);
    int budget;
    budget = 20000;
    while (rx_q.size() < n && budget > 0) begin
      @(posedge r_clk);
      #1;
      if (rnd) begin
        m_ready     = 1'($urandom_range(0, 1));
        force_empty = ($urandom_range(0, 3) == 0);
      end
      budget--;
    end
    m_ready     = 1'b1;
    force_empty = 1'b0;
    ok = (rx_q.size() >= n);
  endtask

  task automatic test_reset();
    logic [IN_W-1:0] w;
    clear_rx();
    for (int k = 0; k < NS; k++) w[k*OUT_W +: OUT_W] = OUT_W'(k + 1);
    push_word(w);
    repeat (3) @(negedge r_clk);
    #1;
    checks++;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0 ||
        word_cnt !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rd_en=%b valid=%b last=%b data=%h cnt=%0d busy=%b, required all zero",
               fifo_rd_en, m_valid, m_last, m_data, word_cnt, busy);
    end
    rst = 1'b0;
    @(posedge r_clk);
    #1;
    t_pop = cyc;
    checks++;
    if (fifo_rd_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_pop: rd_en=%b busy=%b, required 1 1", fifo_rd_en, busy);
    end
    @(posedge r_clk);
    #1;
    checks++;
    if (fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL pop_single_cycle: rd_en=%b, required 0", fifo_rd_en);
    end
  endtask

  task automatic test_single_word();
    bit ok;
    wait_rx(NS, 1'b0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_timeout: got %0d slices, required %0d", rx_q.size(), NS);
    end else begin
      checks++;
      if (rx_cyc[0] != t_pop + RD_LAT + 1) begin
        errors++;
        $display("FAIL first_slice_latency: got cycle %0d, required %0d", rx_cyc[0], t_pop + RD_LAT + 1);
      end
      for (int k = 0; k < NS; k++) begin
        checks++;
        if (rx_q[k] !== exp_q[k] || rx_last[k] != (k == NS-1) || rx_cyc[k] != rx_cyc[0] + k) begin
          errors++;
          $display("FAIL single_slice %0d: data=%h last=%b dcyc=%0d, required %h %b %0d",
                   k, rx_q[k], rx_last[k], rx_cyc[k] - rx_cyc[0], exp_q[k], (k == NS-1), k);
        end
      end
    end
    repeat (3) @(posedge r_clk);
    #1;
    checks++;
    if (word_cnt !== CNT_W'(exp_wc) || busy !== 1'b0 || pops != 1) begin
      errors++;
      $display("FAIL single_end: cnt=%0d busy=%b pops=%0d, required %0d 0 1", word_cnt, busy, pops, exp_wc);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int pops0;
    clear_rx();
    pops0 = pops;
    for (int i = 0; i < 16; i++) begin
      words[i] = rand_word();
      push_word(words[i]);
    end
    wait_rx(16*NS, 1'b0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d slices, required %0d", rx_q.size(), 16*NS);
    end else begin
      for (int k = 0; k < 16*NS; k++) begin
        checks++;
        if (rx_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL b2b_data %0d: got %h, required %h", k, rx_q[k], exp_q[k]);
        end
        if (k > 0) begin
          checks++;
          if (rx_cyc[k] - rx_cyc[k-1] != ((k % NS == 0) ? RD_LAT + 2 : 1)) begin
            errors++;
            $display("FAIL b2b_spacing %0d: got %0d cycles, required %0d",
                     k, rx_cyc[k] - rx_cyc[k-1], (k % NS == 0) ? RD_LAT + 2 : 1);
          end
        end
      end
    end
    repeat (4) @(posedge r_clk);
    #1;
    checks++;
    if (pops - pops0 != 16 || word_cnt !== CNT_W'(exp_wc) || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: pops=%0d cnt=%0d busy=%b, required 16 %0d 0", pops - pops0, word_cnt, busy, exp_wc);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int pops0;
    clear_rx();
    pops0 = pops;
    for (int i = 0; i < 16; i++) push_word(words[i]);
    wait_rx(16*NS, 1'b1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_timeout: got %0d slices, required %0d", rx_q.size(), 16*NS);
    end else begin
      for (int k = 0; k < 16*NS; k++) begin
        checks++;
        if (rx_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL stall_data %0d: got %h, required %h", k, rx_q[k], exp_q[k]);
        end
      end
    end
    repeat (6) @(posedge r_clk);
    #1;
    checks++;
    if (pops - pops0 != 16 || word_cnt !== CNT_W'(exp_wc)) begin
      errors++;
      $display("FAIL stall_end: pops=%0d cnt=%0d, required 16 %0d", pops - pops0, word_cnt, exp_wc);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int budget;
    logic [IN_W-1:0] w;
    clear_rx();
    for (int i = 0; i < 3; i++) push_word(rand_word());
    budget = 2000;
    while (rx_q.size() < NS + 10 && budget > 0) begin
      @(posedge r_clk);
      #1;
      budget--;
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== exp_q[NS+10]) begin
      errors++;
      $display("FAIL mid_presenting: valid=%b data=%h, required 1 %h", m_valid, m_data, exp_q[NS+10]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0 ||
        word_cnt !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: rd_en=%b valid=%b last=%b data=%h cnt=%0d busy=%b, required all zero",
               fifo_rd_en, m_valid, m_last, m_data, word_cnt, busy);
    end
    repeat (2) @(negedge r_clk);
    fifo_q.delete();
    clear_rx();
    exp_wc = 0;
    w = rand_word();
    push_word(w);
    repeat (2) @(negedge r_clk);
    #1;
    rst = 1'b0;
    wait_rx(NS, 1'b0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_timeout: got %0d slices, required %0d", rx_q.size(), NS);
    end else begin
      for (int k = 0; k < NS; k++) begin
        checks++;
        if (rx_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL mid_new_word %0d: got %h, required %h", k, rx_q[k], exp_q[k]);
        end
      end
    end
    repeat (3) @(posedge r_clk);
    #1;
    checks++;
    if (word_cnt !== CNT_W'(exp_wc)) begin
      errors++;
      $display("FAIL mid_count: got %0d, required %0d", word_cnt, exp_wc);
    end
  endtask

  task automatic test_empty_zero();
    bit ok;
    int pops0;
    clear_rx();
    pops0 = pops;
    force_empty = 1'b1;
    push_word('0);
    repeat (40) @(posedge r_clk);
    #1;
    checks++;
    if (pops != pops0 || busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_hold: pops=%0d busy=%b valid=%b, required %0d 0 0", pops, busy, m_valid, pops0);
    end
    force_empty = 1'b0;
    wait_rx(NS, 1'b0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL zero_timeout: got %0d slices, required %0d", rx_q.size(), NS);
    end else begin
      for (int k = 0; k < NS; k++) begin
        checks++;
        if (rx_q[k] !== '0) begin
          errors++;
          $display("FAIL zero_slice %0d: got %h, required 0", k, rx_q[k]);
        end
      end
    end
    repeat (3) @(posedge r_clk);
    #1;
    checks++;
    if (word_cnt !== CNT_W'(exp_wc) || pops - pops0 != 1) begin
      errors++;
      $display("FAIL zero_end: cnt=%0d pops=%0d, required %0d 1", word_cnt, pops - pops0, exp_wc);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_empty_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
